// File: rtl/if_stage_ibuf_if.sv
// Fetch-stage bus bundle: instruction SRAM request/response handshake plus
// the IBUF head presented to the ID stage.
// master = fetch stage, slave = SRAM/ID side (or testbench).
interface if_stage_ibuf_if;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_exc;
    logic [5:0]  out_ecode;
    logic [8:0]  out_esubcode;

    modport master (
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output out_valid, out_pc, out_inst, out_exc, out_ecode, out_esubcode,
        input  out_ready
    );

    modport slave (
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  out_valid, out_pc, out_inst, out_exc, out_ecode, out_esubcode,
        output out_ready
    );
endinterface

// File: rtl/if_stage_ibuf.sv
// Instruction fetch stage with multiple outstanding SRAM requests, an
// in-order PC tag queue and an instruction buffer (IBUF) feeding ID.
// Redirects (ex > ertn > branch) cancel all in-flight responses.
// Optional macro IF_PERF_EN adds fetch/drop performance counters.
module if_stage_ibuf #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int unsigned IBUF_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IF_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt,
`endif
    input  logic        ex_flush,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_entry,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    if_stage_ibuf_if.master bus
);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned PW = $clog2(IBUF_DEPTH);
    localparam logic [OW-1:0] O_ONE = 1;
    localparam logic [CW-1:0] C_ONE = 1;
    localparam logic [PW-1:0] P_ONE = 1;
    localparam logic [5:0]    ECODE_ADEF = 6'h08;

    logic [31:0]   fpc_q, fpc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] cancel_q, cancel_d;
    logic [OW-1:0] tag_cnt_q, tag_cnt_d;
    logic [31:0]   tag_q [MAX_OUTSTANDING];
    logic [31:0]   tag_d [MAX_OUTSTANDING];
    logic          adef_sent_q, adef_sent_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   ibuf_pc_q   [IBUF_DEPTH];
    logic [31:0]   ibuf_pc_d   [IBUF_DEPTH];
    logic [31:0]   ibuf_inst_q [IBUF_DEPTH];
    logic [31:0]   ibuf_inst_d [IBUF_DEPTH];
    logic          ibuf_exc_q  [IBUF_DEPTH];
    logic          ibuf_exc_d  [IBUF_DEPTH];

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [OW-1:0] live;
    logic          req, hs, drop, accept, adef, push, pop, head_valid;

    // Control decode: redirect select, request credit, response routing, ADEF.
    always_comb begin
        redirect    = ex_flush | ertn_flush | br_taken;
        redirect_pc = ex_flush ? ex_entry : (ertn_flush ? ertn_entry : br_target);
        // Cancelled requests never land in the IBUF, so only live ones need space.
        live        = outst_q - cancel_q;
        req         = !rst && !redirect && (fpc_q[1:0] == 2'b00)
                      && (32'(outst_q) < MAX_OUTSTANDING)
                      && ((32'(cnt_q) + 32'(live)) < IBUF_DEPTH);
        hs          = req && bus.inst_sram_addr_ok;
        drop        = bus.inst_sram_data_ok && ((cancel_q != '0) || redirect);
        accept      = bus.inst_sram_data_ok && !drop;
        adef        = !redirect && (fpc_q[1:0] != 2'b00) && !adef_sent_q
                      && (outst_q == '0) && (cancel_q == '0)
                      && (32'(cnt_q) < IBUF_DEPTH);
        head_valid  = (cnt_q != '0);
        push        = accept || adef;
        pop         = head_valid && bus.out_ready && !redirect;
    end

    // Fetch PC, outstanding/cancel bookkeeping and in-order PC tag queue.
    always_comb begin
        fpc_d       = fpc_q;
        outst_d     = outst_q;
        cancel_d    = cancel_q;
        adef_sent_d = adef_sent_q;
        tag_d       = tag_q;
        tag_cnt_d   = tag_cnt_q;

        if (hs && !bus.inst_sram_data_ok) begin
            outst_d = outst_q + O_ONE;
        end else if (!hs && bus.inst_sram_data_ok) begin
            outst_d = outst_q - O_ONE;
        end

        if (redirect) begin
            fpc_d       = redirect_pc;
            adef_sent_d = 1'b0;
            tag_cnt_d   = '0;
            // Everything still in flight after this cycle belongs to the old stream.
            cancel_d    = outst_d;
        end else begin
            if (hs) begin
                fpc_d = fpc_q + 32'd4;
            end
            if (adef) begin
                adef_sent_d = 1'b1;
            end
            if (bus.inst_sram_data_ok && (cancel_q != '0)) begin
                cancel_d = cancel_q - O_ONE;
            end
            if (accept) begin
                for (int unsigned i = 0; i + 1 < MAX_OUTSTANDING; i++) begin
                    tag_d[i] = tag_q[i+1];
                end
                tag_cnt_d = tag_cnt_q - O_ONE;
            end
            if (hs) begin
                for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (32'(tag_cnt_d) == i) begin
                        tag_d[i] = fpc_q;
                    end
                end
                tag_cnt_d = tag_cnt_d + O_ONE;
            end
        end
    end

    // IBUF ring: push returned/ADEF entries at tail, pop head to ID.
    always_comb begin
        ibuf_pc_d   = ibuf_pc_q;
        ibuf_inst_d = ibuf_inst_q;
        ibuf_exc_d  = ibuf_exc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;

        if (redirect) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                ibuf_pc_d[tail_q]   = adef ? fpc_q : tag_q[0];
                ibuf_inst_d[tail_q] = adef ? 32'd0 : bus.inst_sram_rdata;
                ibuf_exc_d[tail_q]  = adef;
                tail_d              = tail_q + P_ONE;
            end
            if (pop) begin
                head_d = head_q + P_ONE;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + C_ONE;
            end else if (!push && pop) begin
                cnt_d = cnt_q - C_ONE;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q       <= RESET_PC;
            outst_q     <= '0;
            cancel_q    <= '0;
            tag_cnt_q   <= '0;
            adef_sent_q <= 1'b0;
            cnt_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            fpc_q       <= fpc_d;
            outst_q     <= outst_d;
            cancel_q    <= cancel_d;
            tag_cnt_q   <= tag_cnt_d;
            adef_sent_q <= adef_sent_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    // Storage arrays; contents are only observed through valid counters.
    always_ff @(posedge clk) begin
        tag_q       <= tag_d;
        ibuf_pc_q   <= ibuf_pc_d;
        ibuf_inst_q <= ibuf_inst_d;
        ibuf_exc_q  <= ibuf_exc_d;
    end

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_addr = {fpc_q[31:2], 2'b00};
    assign bus.out_valid      = head_valid;
    assign bus.out_pc         = head_valid ? ibuf_pc_q[head_q] : '0;
    assign bus.out_inst       = head_valid ? ibuf_inst_q[head_q] : '0;
    assign bus.out_exc        = head_valid && ibuf_exc_q[head_q];
    assign bus.out_ecode      = (head_valid && ibuf_exc_q[head_q]) ? ECODE_ADEF : '0;
    assign bus.out_esubcode   = '0;

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_drop_q, perf_drop_d;

    // Count accepted and dropped responses.
    always_comb begin
        perf_fetch_d = perf_fetch_q + (accept ? 32'd1 : 32'd0);
        perf_drop_d  = perf_drop_q + (drop ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif
endmodule

// File: tb/tb_if_stage_ibuf.sv
// Directed testbench for if_stage_ibuf with an in-order SRAM model that
// returns each accepted request no earlier than the next cycle (rdata = ~addr).
module tb_if_stage_ibuf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_stage_ibuf_if bus();

    logic        ex_flush, ertn_flush, br_taken;
    logic [31:0] ex_entry, ertn_entry, br_target;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

    if_stage_ibuf #(
        .RESET_PC(32'h1c000000),
        .IBUF_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef IF_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_drop_cnt(perf_drop_cnt),
`endif
        .ex_flush(ex_flush),
        .ex_entry(ex_entry),
        .ertn_flush(ertn_flush),
        .ertn_entry(ertn_entry),
        .br_taken(br_taken),
        .br_target(br_target),
        .bus(bus)
    );

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] pend[$];
    logic        resp_en;

    // One clock cycle: capture handshakes mid-cycle, then update the SRAM model.
    task automatic cycle();
        logic        hs_s, dok_s;
        logic [31:0] hs_addr, tmp;
        @(negedge clk);
        hs_s    = bus.inst_sram_req && bus.inst_sram_addr_ok;
        hs_addr = bus.inst_sram_addr;
        dok_s   = bus.inst_sram_data_ok;
        @(posedge clk);
        #1;
        if (dok_s && pend.size() > 0) tmp = pend.pop_front();
        if (hs_s) pend.push_back(hs_addr);
        if (rst) pend.delete();
        bus.inst_sram_data_ok = resp_en && (pend.size() > 0);
        bus.inst_sram_rdata   = bus.inst_sram_data_ok ? ~pend[0] : 32'd0;
    endtask

    // Redirect by branch, then idle long enough for cancelled responses to return.
    task automatic branch_idle(input logic [31:0] tgt);
        bus.inst_sram_addr_ok = 1'b0;
        resp_en   = 1'b1;
        br_target = tgt;
        br_taken  = 1'b1;
        cycle();
        br_taken  = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_flush = 0; ertn_flush = 0; br_taken = 0;
        ex_entry = 0; ertn_entry = 0; br_target = 0;
        resp_en = 0;
        bus.inst_sram_addr_ok = 0; bus.inst_sram_data_ok = 0;
        bus.inst_sram_rdata = 0; bus.out_ready = 0;
        repeat (3) cycle();
        total++; if (bus.inst_sram_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.inst_sram_req); else pass_cnt++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid); else pass_cnt++;
        total++; if (bus.out_pc !== 32'd0) $display("FAIL reset_pc: got %h expected 0", bus.out_pc); else pass_cnt++;
        total++; if (bus.out_inst !== 32'd0) $display("FAIL reset_inst: got %h expected 0", bus.out_inst); else pass_cnt++;
        total++; if ({bus.out_exc, bus.out_ecode, bus.out_esubcode} !== 16'd0)
            $display("FAIL reset_exc: got %h expected 0", {bus.out_exc, bus.out_ecode, bus.out_esubcode}); else pass_cnt++;
`ifdef IF_PERF_EN
        total++; if ({perf_fetch_cnt, perf_drop_cnt} !== 64'd0)
            $display("FAIL reset_perf: got %h expected 0", {perf_fetch_cnt, perf_drop_cnt}); else pass_cnt++;
`endif
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        rst = 1'b0;
        resp_en = 1; bus.inst_sram_addr_ok = 1; bus.out_ready = 1;
        #1;
        total++; if ({bus.inst_sram_req, bus.inst_sram_addr} !== {1'b1, 32'h1c000000})
            $display("FAIL stream_first_req: got %b/%h expected 1/1c000000", bus.inst_sram_req, bus.inst_sram_addr); else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            pc = 32'h1c000000 + 32'(4 * i);
            total++; if ({bus.inst_sram_req, bus.inst_sram_addr} !== {1'b1, pc})
                $display("FAIL stream_req[%0d]: got %b/%h expected 1/%h", i, bus.inst_sram_req, bus.inst_sram_addr, pc); else pass_cnt++;
            if (i == 1) begin
                total++; if (bus.out_valid !== 1'b0) $display("FAIL stream_latency: got valid %b expected 0", bus.out_valid); else pass_cnt++;
            end else begin
                pc = 32'h1c000000 + 32'(4 * (i - 2));
                total++; if ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, pc, ~pc})
                    $display("FAIL stream_out[%0d]: got %b/%h/%h expected 1/%h/%h", i, bus.out_valid, bus.out_pc, bus.out_inst, pc, ~pc); else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc;
        branch_idle(32'h1c000200);
        bus.out_ready = 0;
        bus.inst_sram_addr_ok = 1;
        repeat (7) cycle();
        total++; if (bus.inst_sram_req !== 1'b0) $display("FAIL bp_req_stall: got %b expected 0", bus.inst_sram_req); else pass_cnt++;
        total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h1c000200})
            $display("FAIL bp_head: got %b/%h expected 1/1c000200", bus.out_valid, bus.out_pc); else pass_cnt++;
        bus.inst_sram_addr_ok = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h1c000200 + 32'(4 * i);
            total++; if ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, pc, ~pc})
                $display("FAIL bp_drain[%0d]: got %b/%h/%h expected 1/%h/%h", i, bus.out_valid, bus.out_pc, bus.out_inst, pc, ~pc); else pass_cnt++;
            cycle();
        end
        total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_count: got valid %b after 4 pops expected 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_branch_drop();
        bit found = 0;
`ifdef IF_PERF_EN
        logic [31:0] drop0;
`endif
        branch_idle(32'h1c000300);
        resp_en = 0;
        bus.inst_sram_addr_ok = 1;
        bus.out_ready = 1;
        cycle(); cycle();
        total++; if (bus.inst_sram_req !== 1'b0) $display("FAIL drop_outstanding_cap: got %b expected 0", bus.inst_sram_req); else pass_cnt++;
`ifdef IF_PERF_EN
        drop0 = perf_drop_cnt;
`endif
        br_target = 32'h1c000100;
        br_taken = 1;
        cycle();
        br_taken = 0;
        resp_en = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = bus.out_valid;
        end
        total++; if ({found, bus.out_pc, bus.out_inst} !== {1'b1, 32'h1c000100, ~32'h1c000100})
            $display("FAIL drop_next_pc: got %b/%h/%h expected 1/1c000100/%h", found, bus.out_pc, bus.out_inst, ~32'h1c000100); else pass_cnt++;
`ifdef IF_PERF_EN
        total++; if (perf_drop_cnt - drop0 !== 32'd2) $display("FAIL drop_perf: got %0d expected 2", perf_drop_cnt - drop0); else pass_cnt++;
`endif
    endtask

    task automatic test_priority();
        bit found = 0;
        branch_idle(32'h1c000400);
        ex_entry = 32'h1c008000; ex_flush = 1;
        br_target = 32'h1c000500; br_taken = 1;
        #1;
        total++; if (bus.inst_sram_req !== 1'b0) $display("FAIL prio_req_in_redirect: got %b expected 0", bus.inst_sram_req); else pass_cnt++;
        cycle();
        ex_flush = 0; br_taken = 0;
        #1;
        total++; if ({bus.inst_sram_req, bus.inst_sram_addr} !== {1'b1, 32'h1c008000})
            $display("FAIL prio_fpc: got %b/%h expected 1/1c008000", bus.inst_sram_req, bus.inst_sram_addr); else pass_cnt++;
        bus.inst_sram_addr_ok = 1;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = bus.out_valid;
        end
        total++; if ({found, bus.out_pc} !== {1'b1, 32'h1c008000})
            $display("FAIL prio_out_pc: got %b/%h expected 1/1c008000", found, bus.out_pc); else pass_cnt++;
    endtask

    task automatic test_adef();
        bit found = 0;
        bus.inst_sram_addr_ok = 0;
        bus.out_ready = 0;
        ertn_entry = 32'h1c000102; ertn_flush = 1;
        br_target = 32'h1c000600; br_taken = 1;
        cycle();
        ertn_flush = 0; br_taken = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = bus.out_valid;
        end
        total++; if ({found, bus.out_pc, bus.out_inst} !== {1'b1, 32'h1c000102, 32'd0})
            $display("FAIL adef_entry: got %b/%h/%h expected 1/1c000102/0", found, bus.out_pc, bus.out_inst); else pass_cnt++;
        total++; if ({bus.out_exc, bus.out_ecode, bus.out_esubcode} !== {1'b1, 6'h08, 9'd0})
            $display("FAIL adef_code: got %b/%h/%h expected 1/08/000", bus.out_exc, bus.out_ecode, bus.out_esubcode); else pass_cnt++;
        total++; if (bus.inst_sram_req !== 1'b0) $display("FAIL adef_no_req: got %b expected 0", bus.inst_sram_req); else pass_cnt++;
        bus.out_ready = 1;
        bus.inst_sram_addr_ok = 1;
        repeat (6) cycle();
        total++; if ({bus.out_valid, bus.inst_sram_req} !== 2'b00)
            $display("FAIL adef_stall: got valid/req %b%b expected 00", bus.out_valid, bus.inst_sram_req); else pass_cnt++;
        ex_entry = 32'h1c000400; ex_flush = 1;
        cycle();
        ex_flush = 0;
        #1;
        total++; if ({bus.inst_sram_req, bus.inst_sram_addr} !== {1'b1, 32'h1c000400})
            $display("FAIL adef_release: got %b/%h expected 1/1c000400", bus.inst_sram_req, bus.inst_sram_addr); else pass_cnt++;
    endtask

    task automatic test_dok_redirect();
        bit found = 0;
`ifdef IF_PERF_EN
        logic [31:0] drop0;
`endif
        branch_idle(32'h1c000700);
        bus.out_ready = 1;
        bus.inst_sram_addr_ok = 1;
        cycle();
`ifdef IF_PERF_EN
        drop0 = perf_drop_cnt;
`endif
        // data_ok for 0x1c000700 is now active alongside the branch
        bus.inst_sram_addr_ok = 0;
        br_target = 32'h1c000800; br_taken = 1;
        cycle();
        br_taken = 0;
        bus.inst_sram_addr_ok = 1;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = bus.out_valid;
        end
        total++; if ({found, bus.out_pc, bus.out_inst} !== {1'b1, 32'h1c000800, ~32'h1c000800})
            $display("FAIL dok_redirect_next: got %b/%h/%h expected 1/1c000800/%h", found, bus.out_pc, bus.out_inst, ~32'h1c000800); else pass_cnt++;
`ifdef IF_PERF_EN
        total++; if (perf_drop_cnt - drop0 !== 32'd1) $display("FAIL dok_redirect_perf: got %0d expected 1", perf_drop_cnt - drop0); else pass_cnt++;
`endif
    endtask

    task automatic test_wrap();
        branch_idle(32'hfffffff8);
        bus.inst_sram_addr_ok = 1;
        bus.out_ready = 1;
        #1;
        total++; if (bus.inst_sram_addr !== 32'hfffffff8) $display("FAIL wrap_a0: got %h expected fffffff8", bus.inst_sram_addr); else pass_cnt++;
        cycle();
        total++; if (bus.inst_sram_addr !== 32'hfffffffc) $display("FAIL wrap_a1: got %h expected fffffffc", bus.inst_sram_addr); else pass_cnt++;
        cycle();
        total++; if ({bus.inst_sram_req, bus.inst_sram_addr} !== {1'b1, 32'h00000000})
            $display("FAIL wrap_a2: got %b/%h expected 1/00000000", bus.inst_sram_req, bus.inst_sram_addr); else pass_cnt++;
        total++; if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'hfffffff8})
            $display("FAIL wrap_out: got %b/%h expected 1/fffffff8", bus.out_valid, bus.out_pc); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_drop();
        test_priority();
        test_adef();
        test_dok_redirect();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
